// File: rtl/param_memory_if.sv
// ---------------------------------------------------------------------------
// param_memory_if
// Request/response bundle for param_memory.
//
// Signals
//   req_valid / req_ready   request handshake (accept when both high)
//   req_wr                  1 = write, 0 = read
//   req_addr  [ADDR_W]      word address
//   req_wdata [DATA_W]      write data
//   rd_valid                one-cycle pulse per accepted read
//   rd_data   [DATA_W]      read data, held between rd_valid pulses
//   addr_err                one-cycle pulse after an out-of-range accept
//   busy                    clear sequence in progress
//   perr_inject / rd_perr   parity test/report, only with PARAM_MEMORY_PARITY_EN
//
// Modports: master (bus master / bench), slave (the memory).
// Optional feature macro: PARAM_MEMORY_PARITY_EN.
// ---------------------------------------------------------------------------
interface param_memory_if #(
    parameter int DATA_W = 2,
    parameter int ADDR_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              addr_err;
    logic              busy;
`ifdef PARAM_MEMORY_PARITY_EN
    logic              perr_inject;
    logic              rd_perr;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, perr_inject,
        input  req_ready, rd_valid, rd_data, addr_err, busy, rd_perr
    );
    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, perr_inject,
        output req_ready, rd_valid, rd_data, addr_err, busy, rd_perr
    );
`else
    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rd_valid, rd_data, addr_err, busy
    );
    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rd_valid, rd_data, addr_err, busy
    );
`endif
endinterface

// File: rtl/param_memory.sv
// ---------------------------------------------------------------------------
// param_memory
// Parametrised single-port synchronous memory with a valid/ready request
// handshake, 1- or 2-cycle read latency, a hardware clear sequence after
// reset and out-of-range address detection.
//
// Ports
//   clk   in   single clock, rising edge
//   rst   in   synchronous active-high reset
//   bus   param_memory_if.slave (request in, read response / status out)
//
// Parameters
//   DATA_W   word width
//   ADDR_W   address width
//   DEPTH    number of words, 1..2**ADDR_W
//   RD_LAT   accept-to-rd_valid latency, 1 or 2
//   INIT_VAL value written to every word during clear
//
// Optional feature macro: PARAM_MEMORY_PARITY_EN
//   Adds an even-parity bit per word, bus.perr_inject (invert stored parity
//   on a write) and bus.rd_perr (parity mismatch, qualified by rd_valid).
// ---------------------------------------------------------------------------
module param_memory #(
    parameter int              DATA_W   = 2,
    parameter int              ADDR_W   = 4,
    parameter int              DEPTH    = 16,
    parameter int              RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    param_memory_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            r_state,   w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_next;

    // ------------------------------------------------------------------
    // Control FSM: CLEAR walks every word once, then RUN forever.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        if (r_state == ST_CLEAR) begin
            w_clr_cnt_next = r_clr_cnt + 1'b1;
            if (r_clr_cnt == LAST_ADDR) begin
                w_state_next   = ST_RUN;
                w_clr_cnt_next = '0;
            end
        end
    end

    logic w_ready;
    logic w_accept;
    logic w_rd_accept;
    logic w_in_range;

    assign w_ready     = (r_state == ST_RUN);
    // A request coinciding with reset is not taken; reset owns that edge.
    assign w_accept    = bus.req_valid && w_ready && !rst;
    assign w_rd_accept = w_accept && !bus.req_wr;
    assign w_in_range  = ({1'b0, bus.req_addr} < DEPTH_V);

    assign bus.req_ready = w_ready;
    assign bus.busy      = (r_state == ST_CLEAR);

    // ------------------------------------------------------------------
    // Storage: one write port shared by the clear walker and requests.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = bus.req_addr;
        w_wr_data = bus.req_wdata;
        if (r_state == ST_CLEAR) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_clr_cnt;
            w_wr_data = INIT_VAL;
        end else begin
            // Out-of-range writes are dropped rather than aliased.
            w_wr_en = w_accept && bus.req_wr && w_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Registered array read; no reset so it maps onto RAM output registers.
    logic [DATA_W-1:0] r_rd_word;
    always_ff @(posedge clk) begin
        if (w_rd_accept && w_in_range) begin
            r_rd_word <= r_mem[bus.req_addr];
        end
    end

    // r_rd_zero masks the RAM word: set by reset (rd_data resets to 0) and
    // by an out-of-range read (which must return 0).
    logic r_rd_v;
    logic r_rd_zero;
    logic r_addr_err;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_v     <= 1'b0;
            r_rd_zero  <= 1'b1;
            r_addr_err <= 1'b0;
        end else begin
            r_rd_v     <= w_rd_accept;
            r_addr_err <= w_accept && !w_in_range;
            if (w_rd_accept) begin
                r_rd_zero <= !w_in_range;
            end
        end
    end

    assign bus.addr_err = r_addr_err;

`ifdef PARAM_MEMORY_PARITY_EN
    // Parity bit array alongside the data array.
    logic r_mem_par [DEPTH];
    logic w_wr_par;
    logic r_rd_par;

    always_comb begin
        w_wr_par = ^w_wr_data;
        if (r_state == ST_RUN) begin
            w_wr_par = (^w_wr_data) ^ bus.perr_inject;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_par[w_wr_addr] <= w_wr_par;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_accept && w_in_range) begin
            r_rd_par <= r_mem_par[bus.req_addr];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output pipeline. Stage 0 is the RAM read register; stages 1..RD_LAT-1
    // are plain registers. Data/parity only advance with a valid token so
    // rd_data holds its value between pulses.
    // ------------------------------------------------------------------
    logic              w_s_v [RD_LAT];
    logic [DATA_W-1:0] w_s_d [RD_LAT];

    assign w_s_v[0] = r_rd_v;
    assign w_s_d[0] = r_rd_zero ? '0 : r_rd_word;

`ifdef PARAM_MEMORY_PARITY_EN
    logic w_s_p [RD_LAT];
    assign w_s_p[0] = !r_rd_zero && (r_rd_par != ^r_rd_word);
`endif

    genvar gi;
    generate
        for (gi = 1; gi < RD_LAT; gi++) begin : g_stage
            logic              r_v;
            logic [DATA_W-1:0] r_d;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= 1'b0;
                    r_d <= '0;
                end else begin
                    r_v <= w_s_v[gi-1];
                    if (w_s_v[gi-1]) begin
                        r_d <= w_s_d[gi-1];
                    end
                end
            end
            assign w_s_v[gi] = r_v;
            assign w_s_d[gi] = r_d;
`ifdef PARAM_MEMORY_PARITY_EN
            logic r_p;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_p <= 1'b0;
                end else if (w_s_v[gi-1]) begin
                    r_p <= w_s_p[gi-1];
                end
            end
            assign w_s_p[gi] = r_p;
`endif
        end
    endgenerate

    assign bus.rd_valid = w_s_v[RD_LAT-1];
    assign bus.rd_data  = w_s_d[RD_LAT-1];
`ifdef PARAM_MEMORY_PARITY_EN
    assign bus.rd_perr  = w_s_v[RD_LAT-1] && w_s_p[RD_LAT-1];
`endif

endmodule

// File: tb/tb_param_memory.sv
// ---------------------------------------------------------------------------
// tb_param_memory
// Two instances share one request stream:
//   u_dut   : defaults (DEPTH=16, RD_LAT=1)
//   u_dut_b : DEPTH=12, RD_LAT=2 (exercises out-of-range and 2-cycle latency)
// Responses are logged per sample cycle and checked against hand-computed
// values in each scenario task.
// ---------------------------------------------------------------------------
module tb_param_memory;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    param_memory_if #(.DATA_W(2), .ADDR_W(4)) if_a ();
    param_memory_if #(.DATA_W(2), .ADDR_W(4)) if_b ();

    assign if_b.req_valid = if_a.req_valid;
    assign if_b.req_wr    = if_a.req_wr;
    assign if_b.req_addr  = if_a.req_addr;
    assign if_b.req_wdata = if_a.req_wdata;
`ifdef PARAM_MEMORY_PARITY_EN
    assign if_b.perr_inject = if_a.perr_inject;
`endif

    param_memory #(.DATA_W(2), .ADDR_W(4), .DEPTH(16), .RD_LAT(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    param_memory #(.DATA_W(2), .ADDR_W(4), .DEPTH(12), .RD_LAT(2)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Operation list for run_ops
    int   ops_n;
    logic op_wr   [32];
    int   op_addr [32];
    int   op_data [32];
    logic op_inj  [32];

    // Observed responses: sample index of each rd_valid, data, parity flag
    int       ga_c[$];
    logic [1:0] ga_d[$];
    logic     ga_p[$];
    int       gb_c[$];
    logic [1:0] gb_d[$];
    logic     gb_p[$];
    int       ea[$];
    int       eb[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_a.req_valid = 1'b0;
        if_a.req_wr    = 1'b0;
        if_a.req_addr  = '0;
        if_a.req_wdata = '0;
`ifdef PARAM_MEMORY_PARITY_EN
        if_a.perr_inject = 1'b0;
`endif
    endtask

    task automatic clear_ops();
        ops_n = 0;
    endtask

    task automatic add_op(input logic wr, input int addr, input int data, input logic inj);
        op_wr[ops_n]   = wr;
        op_addr[ops_n] = addr;
        op_data[ops_n] = data;
        op_inj[ops_n]  = inj;
        ops_n++;
    endtask

    task automatic sample(input int c);
        if (if_a.rd_valid) begin
            ga_c.push_back(c);
            ga_d.push_back(if_a.rd_data);
`ifdef PARAM_MEMORY_PARITY_EN
            ga_p.push_back(if_a.rd_perr);
`else
            ga_p.push_back(1'b0);
`endif
        end
        if (if_b.rd_valid) begin
            gb_c.push_back(c);
            gb_d.push_back(if_b.rd_data);
`ifdef PARAM_MEMORY_PARITY_EN
            gb_p.push_back(if_b.rd_perr);
`else
            gb_p.push_back(1'b0);
`endif
        end
        if (if_a.addr_err) ea.push_back(c);
        if (if_b.addr_err) eb.push_back(c);
    endtask

    // One op per cycle, then n_idle idle cycles. Sample k follows edge k,
    // which is the edge that accepts op k.
    task automatic run_ops(input int n_idle);
        int c;
        ga_c.delete(); ga_d.delete(); ga_p.delete();
        gb_c.delete(); gb_d.delete(); gb_p.delete();
        ea.delete(); eb.delete();
        c = 0;
        for (int i = 0; i < ops_n; i++) begin
            if_a.req_valid = 1'b1;
            if_a.req_wr    = op_wr[i];
            if_a.req_addr  = 4'(op_addr[i]);
            if_a.req_wdata = 2'(op_data[i]);
`ifdef PARAM_MEMORY_PARITY_EN
            if_a.perr_inject = op_inj[i];
`endif
            step();
            sample(c);
            c++;
        end
        idle_inputs();
        for (int i = 0; i < n_idle; i++) begin
            step();
            sample(c);
            c++;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int na;
        int nb;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (if_a.busy !== 1'b1 || if_a.req_ready !== 1'b0 || if_a.rd_valid !== 1'b0 ||
            if_a.rd_data !== 2'b00 || if_a.addr_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_a got busy=%b ready=%b rdv=%b rdd=%b aerr=%b want 1 0 0 00 0",
                     if_a.busy, if_a.req_ready, if_a.rd_valid, if_a.rd_data, if_a.addr_err);
        end
        checks++;
        if (if_b.busy !== 1'b1 || if_b.req_ready !== 1'b0 || if_b.rd_valid !== 1'b0 ||
            if_b.rd_data !== 2'b00 || if_b.addr_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_b got busy=%b ready=%b rdv=%b rdd=%b aerr=%b want 1 0 0 00 0",
                     if_b.busy, if_b.req_ready, if_b.rd_valid, if_b.rd_data, if_b.addr_err);
        end
        rst = 1'b0;
        na = 0;
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (if_a.busy) na++;
            if (if_b.busy) nb++;
            step();
        end
        checks++;
        if (na != 16) begin
            failures++;
            $display("FAIL clear_len_a got=%0d want=16", na);
        end
        checks++;
        if (nb != 12) begin
            failures++;
            $display("FAIL clear_len_b got=%0d want=12", nb);
        end
        checks++;
        if (if_a.req_ready !== 1'b1 || if_a.busy !== 1'b0) begin
            failures++;
            $display("FAIL run_state_a got ready=%b busy=%b want 1 0", if_a.req_ready, if_a.busy);
        end
        $display("test_reset: clear cycles a=%0d b=%0d", na, nb);
    endtask

    task automatic test_read_cleared();
        clear_ops();
        for (int i = 0; i < 16; i++) add_op(1'b0, i, 0, 1'b0);
        run_ops(4);
        checks++;
        if (ga_c.size() != 16 || gb_c.size() != 16) begin
            failures++;
            $display("FAIL cleared_count got a=%0d b=%0d want 16 16", ga_c.size(), gb_c.size());
        end
        for (int i = 0; i < ga_c.size() && i < 16; i++) begin
            checks++;
            if (ga_c[i] != i || ga_d[i] !== 2'b00) begin
                failures++;
                $display("FAIL cleared_a%0d got cyc=%0d data=%0d want cyc=%0d data=0", i, ga_c[i], ga_d[i], i);
            end
        end
        for (int i = 0; i < gb_c.size() && i < 16; i++) begin
            checks++;
            if (gb_c[i] != i + 1 || gb_d[i] !== 2'b00) begin
                failures++;
                $display("FAIL cleared_b%0d got cyc=%0d data=%0d want cyc=%0d data=0", i, gb_c[i], gb_d[i], i + 1);
            end
        end
        checks++;
        if (ea.size() != 0) begin
            failures++;
            $display("FAIL cleared_aerr_a got=%0d pulses want=0", ea.size());
        end
        checks++;
        if (eb.size() != 4 || (eb.size() == 4 && (eb[0] != 12 || eb[3] != 15))) begin
            failures++;
            $display("FAIL cleared_aerr_b got=%0d pulses want=4 at 12..15", eb.size());
        end
        $display("test_read_cleared: a_pulses=%0d b_pulses=%0d b_aerr=%0d", ga_c.size(), gb_c.size(), eb.size());
    endtask

    task automatic test_raw();
        clear_ops();
        add_op(1'b1, 3, 2, 1'b0);
        add_op(1'b0, 3, 0, 1'b0);
        run_ops(4);
        checks++;
        if (ga_c.size() != 1 || (ga_c.size() == 1 && (ga_c[0] != 1 || ga_d[0] !== 2'b10))) begin
            failures++;
            $display("FAIL raw_a got n=%0d cyc=%0d data=%0d want n=1 cyc=1 data=2",
                     ga_c.size(), (ga_c.size() > 0) ? ga_c[0] : -1, (ga_d.size() > 0) ? ga_d[0] : 2'b00);
        end
        checks++;
        if (gb_c.size() != 1 || (gb_c.size() == 1 && (gb_c[0] != 2 || gb_d[0] !== 2'b10))) begin
            failures++;
            $display("FAIL raw_b got n=%0d cyc=%0d data=%0d want n=1 cyc=2 data=2",
                     gb_c.size(), (gb_c.size() > 0) ? gb_c[0] : -1, (gb_d.size() > 0) ? gb_d[0] : 2'b00);
        end
        checks++;
        if (if_a.rd_data !== 2'b10 || if_b.rd_data !== 2'b10) begin
            failures++;
            $display("FAIL raw_hold got a=%b b=%b want 10 10", if_a.rd_data, if_b.rd_data);
        end
        $display("test_raw: a_pulses=%0d b_pulses=%0d", ga_c.size(), gb_c.size());
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_d [4];
        exp_d[0] = 2'd1; exp_d[1] = 2'd2; exp_d[2] = 2'd3; exp_d[3] = 2'd0;
        clear_ops();
        add_op(1'b1, 0, 1, 1'b0);
        add_op(1'b1, 1, 2, 1'b0);
        add_op(1'b1, 2, 3, 1'b0);
        add_op(1'b1, 3, 0, 1'b0);
        for (int i = 0; i < 4; i++) add_op(1'b0, i, 0, 1'b0);
        run_ops(4);
        checks++;
        if (ga_c.size() != 4 || gb_c.size() != 4) begin
            failures++;
            $display("FAIL b2b_count got a=%0d b=%0d want 4 4", ga_c.size(), gb_c.size());
        end
        for (int i = 0; i < ga_c.size() && i < 4; i++) begin
            checks++;
            if (ga_c[i] != 4 + i || ga_d[i] !== exp_d[i]) begin
                failures++;
                $display("FAIL b2b_a%0d got cyc=%0d data=%0d want cyc=%0d data=%0d", i, ga_c[i], ga_d[i], 4 + i, exp_d[i]);
            end
        end
        for (int i = 0; i < gb_c.size() && i < 4; i++) begin
            checks++;
            if (gb_c[i] != 5 + i || gb_d[i] !== exp_d[i]) begin
                failures++;
                $display("FAIL b2b_b%0d got cyc=%0d data=%0d want cyc=%0d data=%0d", i, gb_c[i], gb_d[i], 5 + i, exp_d[i]);
            end
        end
        $display("test_back_to_back: a_pulses=%0d b_pulses=%0d", ga_c.size(), gb_c.size());
    endtask

    // Addr 13 is in range for u_dut, out of range for u_dut_b (DEPTH=12).
    // 13 mod 12 = 1, so reading addr 1 also catches an aliased write.
    task automatic test_out_of_range();
        clear_ops();
        add_op(1'b1, 13, 3, 1'b0);
        add_op(1'b0, 13, 0, 1'b0);
        add_op(1'b0, 1, 0, 1'b0);
        run_ops(4);
        checks++;
        if (ga_c.size() != 2 || (ga_c.size() == 2 && (ga_d[0] !== 2'b11 || ga_d[1] !== 2'b10 || ga_c[0] != 1))) begin
            failures++;
            $display("FAIL oor_a got n=%0d want n=2 data 3,2", ga_c.size());
        end
        checks++;
        if (ea.size() != 0) begin
            failures++;
            $display("FAIL oor_aerr_a got=%0d pulses want=0", ea.size());
        end
        checks++;
        if (eb.size() != 2 || (eb.size() == 2 && (eb[0] != 0 || eb[1] != 1))) begin
            failures++;
            $display("FAIL oor_aerr_b got=%0d pulses want=2 at 0,1", eb.size());
        end
        checks++;
        if (gb_c.size() != 2 || (gb_c.size() == 2 && (gb_c[0] != 2 || gb_d[0] !== 2'b00))) begin
            failures++;
            $display("FAIL oor_read_b got n=%0d cyc=%0d data=%0d want n=2 cyc=2 data=0",
                     gb_c.size(), (gb_c.size() > 0) ? gb_c[0] : -1, (gb_d.size() > 0) ? gb_d[0] : 2'b00);
        end
        checks++;
        if (gb_c.size() == 2 && (gb_c[1] != 3 || gb_d[1] !== 2'b10)) begin
            failures++;
            $display("FAIL oor_addr1_b got cyc=%0d data=%0d want cyc=3 data=2", gb_c[1], gb_d[1]);
        end
        $display("test_out_of_range: b_aerr=%0d b_pulses=%0d", eb.size(), gb_c.size());
    endtask

    task automatic test_reset_flush();
        int na;
        int nb;
        int npulse;
        logic vb1;
        idle_inputs();
        // Reset again part-way through a clear.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        na = 0;
        nb = 0;
        npulse = 0;
        for (int k = 0; k < 20; k++) begin
            // Write attempts while busy must be ignored.
            if (k < 10) begin
                if_a.req_valid = 1'b1;
                if_a.req_wr    = 1'b1;
                if_a.req_addr  = 4'd2;
                if_a.req_wdata = 2'b11;
            end else begin
                idle_inputs();
            end
            if (if_a.busy) na++;
            if (if_b.busy) nb++;
            step();
            if (if_a.rd_valid || if_b.rd_valid) npulse++;
        end
        checks++;
        if (na != 16 || nb != 12) begin
            failures++;
            $display("FAIL midclear_len got a=%0d b=%0d want 16 12", na, nb);
        end
        // Reads in flight, then reset.
        if_a.req_valid = 1'b1;
        if_a.req_wr    = 1'b0;
        if_a.req_addr  = 4'd4;
        step();
        if_a.req_addr  = 4'd5;
        step();
        vb1 = if_b.rd_valid;
        rst = 1'b1;
        step();
        checks++;
        if (vb1 !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre_b got rdv=%b want 1", vb1);
        end
        checks++;
        if (if_a.rd_valid !== 1'b0 || if_b.rd_valid !== 1'b0 || if_b.rd_data !== 2'b00 || if_a.rd_data !== 2'b00) begin
            failures++;
            $display("FAIL flush_post got a_rdv=%b b_rdv=%b a_rdd=%b b_rdd=%b want 0 0 00 00",
                     if_a.rd_valid, if_b.rd_valid, if_a.rd_data, if_b.rd_data);
        end
        rst = 1'b0;
        idle_inputs();
        na = 0;
        for (int k = 0; k < 20; k++) begin
            if (if_a.busy) na++;
            step();
            if (if_a.rd_valid || if_b.rd_valid) npulse++;
        end
        checks++;
        if (npulse != 0) begin
            failures++;
            $display("FAIL flush_pulses got=%0d want=0", npulse);
        end
        checks++;
        if (na != 16) begin
            failures++;
            $display("FAIL flush_clear_len_a got=%0d want=16", na);
        end
        $display("test_reset_flush: stray_pulses=%0d clear_a=%0d", npulse, na);
    endtask

    task automatic test_busy_ignored();
        clear_ops();
        add_op(1'b0, 2, 0, 1'b0);
        run_ops(3);
        checks++;
        if (ga_d.size() != 1 || gb_d.size() != 1 ||
            (ga_d.size() == 1 && gb_d.size() == 1 && (ga_d[0] !== 2'b00 || gb_d[0] !== 2'b00))) begin
            failures++;
            $display("FAIL busy_ignored got na=%0d nb=%0d want one zero read each", ga_d.size(), gb_d.size());
        end
        $display("test_busy_ignored: a_pulses=%0d b_pulses=%0d", ga_d.size(), gb_d.size());
    endtask

`ifdef PARAM_MEMORY_PARITY_EN
    task automatic test_parity();
        logic [1:0] exp_d [4];
        logic       exp_p [4];
        exp_d[0] = 2'd0; exp_d[1] = 2'd1; exp_d[2] = 2'd1; exp_d[3] = 2'd0;
        exp_p[0] = 1'b0; exp_p[1] = 1'b1; exp_p[2] = 1'b0; exp_p[3] = 1'b0;
        clear_ops();
        add_op(1'b0, 5, 0, 1'b0);
        add_op(1'b1, 7, 1, 1'b1);
        add_op(1'b0, 7, 0, 1'b0);
        add_op(1'b1, 7, 1, 1'b0);
        add_op(1'b0, 7, 0, 1'b0);
        add_op(1'b0, 14, 0, 1'b0);
        run_ops(4);
        checks++;
        if (ga_c.size() != 4 || gb_c.size() != 4) begin
            failures++;
            $display("FAIL parity_count got a=%0d b=%0d want 4 4", ga_c.size(), gb_c.size());
        end
        for (int i = 0; i < ga_c.size() && i < 4; i++) begin
            checks++;
            if (ga_d[i] !== exp_d[i] || ga_p[i] !== exp_p[i]) begin
                failures++;
                $display("FAIL parity_a%0d got data=%0d perr=%b want data=%0d perr=%b", i, ga_d[i], ga_p[i], exp_d[i], exp_p[i]);
            end
        end
        for (int i = 0; i < gb_c.size() && i < 4; i++) begin
            checks++;
            if (gb_d[i] !== exp_d[i] || gb_p[i] !== exp_p[i]) begin
                failures++;
                $display("FAIL parity_b%0d got data=%0d perr=%b want data=%0d perr=%b", i, gb_d[i], gb_p[i], exp_d[i], exp_p[i]);
            end
        end
        $display("test_parity: a_pulses=%0d b_pulses=%0d", ga_c.size(), gb_c.size());
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_read_cleared();
        test_raw();
        test_back_to_back();
        test_out_of_range();
        test_reset_flush();
        test_busy_ignored();
`ifdef PARAM_MEMORY_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
